// File: rtl/addr_stream_gen_if.sv
// Valid/ready address channel between the stream generator and the cache access port.
interface addr_stream_gen_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] address;
  logic                  last;

  modport master (output addr_valid, address, last, input addr_ready);
  modport slave  (input addr_valid, address, last, output addr_ready);
endinterface

// File: rtl/addr_stream_gen.sv
// Bounded address-stream source: sequential, strided, looping or LFSR patterns,
// NUM_ADDR addresses per run over a valid/ready channel.
module addr_stream_gen #(
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_ADDR   = 10000,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [7:0]            loop_len,
  addr_stream_gen_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  issued_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_ADDR - 1);

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, stride_q, stride_d;
  logic [7:0]            len_q, len_d, off_q, off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]            off_inc, off_nxt;
  logic                  valid_q, valid_d, last_q, last_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Pattern step from the current address; only the captured configuration is used.
  always_comb begin
    off_inc = off_q + 8'd1;
    off_nxt = (off_inc == len_q) ? 8'd0 : off_inc;
    case (mode_q)
      2'd0:    addr_nxt = addr_q + ADDR_WIDTH'(1);
      2'd1:    addr_nxt = addr_q + stride_q;
      2'd2:    addr_nxt = base_q + ADDR_WIDTH'(off_nxt);
      default: addr_nxt = {addr_q[ADDR_WIDTH-2:0],
                           addr_q[ADDR_WIDTH-1] ^ addr_q[ADDR_WIDTH-3]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    stride_d = stride_q;
    len_d    = len_q;
    off_d    = off_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    if (state_q != RUN && start) begin
      state_d  = RUN;
      mode_d   = mode;
      base_d   = base;
      stride_d = stride;
      len_d    = (loop_len == 8'd0) ? 8'd1 : loop_len;
      off_d    = 8'd0;
      // An all-zero LFSR seed would lock up, so it is promoted to 1.
      addr_d   = (mode == 2'd3 && base == '0) ? ADDR_WIDTH'(1) : base;
      valid_d  = 1'b1;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      cnt_d    = '0;
      last_d   = (LAST_IDX == '0);
    end else if (state_q == RUN && valid_q && bus.addr_ready) begin
      cnt_d  = cnt_q + CNT_WIDTH'(1);
      off_d  = off_nxt;
      addr_d = addr_nxt;
      if (cnt_q == LAST_IDX) begin
        state_d = DONE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        last_d = (cnt_q + CNT_WIDTH'(1) == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 2'd0;
      base_q   <= '0;
      stride_q <= '0;
      len_q    <= 8'd1;
      off_q    <= 8'd0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.addr_valid = valid_q;
  assign bus.address    = addr_q;
  assign bus.last       = last_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign issued_count   = cnt_q;
endmodule

// File: tb/tb_addr_stream_gen.sv
// Directed bench: a 4-address instance for run/start/done edges and a 2047-address
// instance for loop, LFSR period, backpressure and mid-run reset.
module tb_addr_stream_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [10:0] base = '0, stride = '0;
  logic [7:0]  loop_len = '0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] cnt_a, cnt_b;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  addr_stream_gen_if #(.ADDR_WIDTH(11)) if_a ();
  addr_stream_gen_if #(.ADDR_WIDTH(11)) if_b ();

  addr_stream_gen #(.ADDR_WIDTH(11), .NUM_ADDR(4), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode), .base(base),
    .stride(stride), .loop_len(loop_len), .bus(if_a),
    .busy(busy_a), .done(done_a), .issued_count(cnt_a));

  addr_stream_gen #(.ADDR_WIDTH(11), .NUM_ADDR(2047), .CNT_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode), .base(base),
    .stride(stride), .loop_len(loop_len), .bus(if_b),
    .busy(busy_b), .done(done_b), .issued_count(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Pulse start for one edge; returns just after the edge that entered RUN.
  task automatic kick(input bit use_b, input logic [1:0] m, input logic [10:0] b,
                      input logic [10:0] s, input logic [7:0] l);
    mode = m; base = b; stride = s; loop_len = l;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    reset_all();
    total++;
    if (if_a.addr_valid !== 1'b0 || if_a.last !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        if_a.address !== 11'h000 || cnt_a !== 32'd0) begin
      bad++;
      $display("FAIL reset_a valid=%b last=%b busy=%b done=%b addr=%h cnt=%0d exp all 0",
               if_a.addr_valid, if_a.last, busy_a, done_a, if_a.address, cnt_a);
    end
    total++;
    if (if_b.addr_valid !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 || cnt_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_b valid=%b busy=%b done=%b cnt=%0d exp all 0",
               if_b.addr_valid, busy_b, done_b, cnt_b);
    end
  endtask

  task automatic test_seq_wrap();
    logic [10:0] exp [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
    reset_all();
    if_a.addr_ready = 1'b1;
    kick(1'b0, 2'd0, 11'h7FE, 11'd0, 8'd0);
    total++;
    if (busy_a !== 1'b1) begin
      bad++; $display("FAIL seq_busy got=%b exp=1", busy_a);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if_a.addr_valid !== 1'b1 || if_a.address !== exp[i]) begin
        bad++;
        $display("FAIL seq_addr%0d valid=%b addr=%h exp=%h", i, if_a.addr_valid, if_a.address, exp[i]);
      end
      total++;
      if (if_a.last !== (i == 3)) begin
        bad++; $display("FAIL seq_last%0d got=%b exp=%b", i, if_a.last, (i == 3));
      end
      tick();
    end
    total++;
    if (done_a !== 1'b1 || cnt_a !== 32'd4 || if_a.addr_valid !== 1'b0 || if_a.last !== 1'b0 ||
        busy_a !== 1'b0) begin
      bad++;
      $display("FAIL seq_done done=%b cnt=%0d valid=%b last=%b busy=%b exp 1/4/0/0/0",
               done_a, cnt_a, if_a.addr_valid, if_a.last, busy_a);
    end
  endtask

  task automatic test_strided();
    logic [10:0] exp [4] = '{11'h005, 11'h008, 11'h00B, 11'h00E};
    reset_all();
    if_a.addr_ready = 1'b1;
    kick(1'b0, 2'd1, 11'h005, 11'd3, 8'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if_a.addr_valid !== 1'b1 || if_a.address !== exp[i]) begin
        bad++;
        $display("FAIL stride_addr%0d valid=%b addr=%h exp=%h", i, if_a.addr_valid, if_a.address, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_loop();
    logic [10:0] exp [5] = '{11'h100, 11'h101, 11'h102, 11'h100, 11'h101};
    reset_all();
    if_b.addr_ready = 1'b1;
    kick(1'b1, 2'd2, 11'h100, 11'd0, 8'd3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (if_b.address !== exp[i]) begin
        bad++; $display("FAIL loop_addr%0d got=%h exp=%h", i, if_b.address, exp[i]);
      end
      tick();
    end
    reset_all();
    kick(1'b1, 2'd2, 11'h100, 11'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (if_b.address !== 11'h100 || if_b.addr_valid !== 1'b1) begin
        bad++; $display("FAIL loop0_addr%0d got=%h exp=100", i, if_b.address);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [10:0] exp [10] = '{11'h001, 11'h002, 11'h004, 11'h008, 11'h010,
                              11'h020, 11'h040, 11'h080, 11'h100, 11'h201};
    bit seen [2048];
    int dup = 0;
    reset_all();
    if_b.addr_ready = 1'b1;
    kick(1'b1, 2'd3, 11'h001, 11'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (if_b.address !== exp[i]) begin
        bad++; $display("FAIL rand_addr%0d got=%h exp=%h", i, if_b.address, exp[i]);
      end
      tick();
    end
    reset_all();
    kick(1'b1, 2'd3, 11'h000, 11'd0, 8'd0);
    total++;
    if (if_b.address !== 11'h001) begin
      bad++; $display("FAIL rand_seed0 got=%h exp=001", if_b.address);
    end
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
    for (int i = 0; i < 2047; i++) begin
      if (if_b.address == 11'h000 || seen[if_b.address]) dup++;
      seen[if_b.address] = 1'b1;
      if (i == 2046) begin
        total++;
        if (if_b.last !== 1'b1) begin
          bad++; $display("FAIL rand_last got=%b exp=1", if_b.last);
        end
      end
      tick();
    end
    total++;
    if (dup !== 0) begin
      bad++; $display("FAIL rand_unique repeats_or_zero=%0d exp=0", dup);
    end
    total++;
    if (done_b !== 1'b1 || cnt_b !== 32'd2047) begin
      bad++; $display("FAIL rand_done done=%b cnt=%0d exp 1/2047", done_b, cnt_b);
    end
  endtask

  task automatic test_backpressure();
    reset_all();
    if_b.addr_ready = 1'b1;
    kick(1'b1, 2'd0, 11'h010, 11'd0, 8'd0);
    tick();
    if_b.addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (if_b.address !== 11'h011 || if_b.addr_valid !== 1'b1 || cnt_b !== 32'd1 ||
          if_b.last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d addr=%h valid=%b cnt=%0d last=%b exp 011/1/1/0",
                 i, if_b.address, if_b.addr_valid, cnt_b, if_b.last);
      end
    end
    if_b.addr_ready = 1'b1;
    tick();
    total++;
    if (if_b.address !== 11'h012 || cnt_b !== 32'd2) begin
      bad++; $display("FAIL bp_resume1 addr=%h cnt=%0d exp 012/2", if_b.address, cnt_b);
    end
    tick();
    total++;
    if (if_b.address !== 11'h013 || cnt_b !== 32'd3) begin
      bad++; $display("FAIL bp_resume2 addr=%h cnt=%0d exp 013/3", if_b.address, cnt_b);
    end
  endtask

  task automatic test_start_midrun();
    reset_all();
    if_a.addr_ready = 1'b1;
    kick(1'b0, 2'd0, 11'h020, 11'd0, 8'd0);
    tick();
    mode = 2'd1; base = 11'h300; stride = 11'd5;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    total++;
    if (if_a.address !== 11'h022 || cnt_a !== 32'd2) begin
      bad++; $display("FAIL mid_start addr=%h cnt=%0d exp 022/2", if_a.address, cnt_a);
    end
    tick();
    total++;
    if (if_a.address !== 11'h023 || if_a.last !== 1'b1) begin
      bad++; $display("FAIL mid_last addr=%h last=%b exp 023/1", if_a.address, if_a.last);
    end
    tick();
    total++;
    if (done_a !== 1'b1 || cnt_a !== 32'd4) begin
      bad++; $display("FAIL mid_done done=%b cnt=%0d exp 1/4", done_a, cnt_a);
    end
  endtask

  task automatic test_start_in_done();
    tick();
    tick();
    total++;
    if (done_a !== 1'b1 || if_a.addr_valid !== 1'b0 || cnt_a !== 32'd4) begin
      bad++;
      $display("FAIL done_hold done=%b valid=%b cnt=%0d exp 1/0/4", done_a, if_a.addr_valid, cnt_a);
    end
    kick(1'b0, 2'd0, 11'h040, 11'd0, 8'd0);
    total++;
    if (done_a !== 1'b0 || if_a.addr_valid !== 1'b1 || cnt_a !== 32'd0 ||
        if_a.address !== 11'h040 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL done_restart done=%b valid=%b cnt=%0d addr=%h busy=%b exp 0/1/0/040/1",
               done_a, if_a.addr_valid, cnt_a, if_a.address, busy_a);
    end
    tick();
    total++;
    if (if_a.address !== 11'h041 || cnt_a !== 32'd1) begin
      bad++; $display("FAIL done_run2 addr=%h cnt=%0d exp 041/1", if_a.address, cnt_a);
    end
  endtask

  task automatic test_reset_midrun();
    reset_all();
    if_b.addr_ready = 1'b1;
    kick(1'b1, 2'd0, 11'h000, 11'd0, 8'd0);
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (cnt_b !== 32'd5 || if_b.address !== 11'h005) begin
      bad++; $display("FAIL rst_pre cnt=%0d addr=%h exp 5/005", cnt_b, if_b.address);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (if_b.addr_valid !== 1'b0 || if_b.last !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0 ||
        if_b.address !== 11'h000 || cnt_b !== 32'd0) begin
      bad++;
      $display("FAIL rst_async valid=%b last=%b busy=%b done=%b addr=%h cnt=%0d exp all 0",
               if_b.addr_valid, if_b.last, busy_b, done_b, if_b.address, cnt_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (if_b.addr_valid !== 1'b0 || busy_b !== 1'b0 || cnt_b !== 32'd0) begin
      bad++;
      $display("FAIL rst_idle valid=%b busy=%b cnt=%0d exp 0/0/0", if_b.addr_valid, busy_b, cnt_b);
    end
  endtask

  initial begin
    if_a.addr_ready = 1'b0;
    if_b.addr_ready = 1'b0;
    test_reset();
    test_seq_wrap();
    test_strided();
    test_loop();
    test_random();
    test_backpressure();
    test_start_midrun();
    test_start_in_done();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_stream_gen.md
# addr_stream_gen

Synthesizable address-stream source that drives the access port of the L1/L2 cache hierarchy. It replaces a fixed trace memory with four configurable access patterns: sequential, strided, looping and pseudo-random. It emits a bounded run of `NUM_ADDR` addresses over a valid/ready handshake, with `last` marking the final address. It sits upstream of the cache `top` and feeds its `address` input.

## Interface
- `ADDR_WIDTH`, 11: address width in bits. Mode 3 (random) is defined only for 11.
- `NUM_ADDR`, 10000: addresses per run. Must be ≥1.
- `CNT_WIDTH`, 32: width of `issued_count`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run. Sampled in IDLE and DONE only.
- `mode` in 2: pattern select. 0 = sequential, 1 = strided, 2 = loop, 3 = random.
- `base` in ADDR_WIDTH: first address; also the seed in mode 3.
- `stride` in ADDR_WIDTH: increment used in mode 1.
- `loop_len` in 8: loop length used in mode 2. A value of 0 is treated as 1.
- `addr_valid` out 1: `address` is valid.
- `addr_ready` in 1: the consumer accepts the address.
- `address` out ADDR_WIDTH: current address.
- `last` out 1: high with the final address of the run.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `issued_count` out CNT_WIDTH: number of completed transfers in the current run.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE, `start`=1 → RUN.
  - RUN, final transfer → DONE.
  - DONE, `start`=1 → RUN, beginning a new run.
  - DONE, `start`=0 → stay in DONE.
- **Configuration capture:** `mode`, `base`, `stride` and `loop_len` are registered at the accepted `start`. Changes to these inputs during RUN have no effect.
- **Start in RUN:** ignored.
- **Transfer:** occurs on a cycle where `addr_valid`=1 and `addr_ready`=1. Each transfer increments `issued_count` and the internal index, and advances `address`.
- **Next-address rules:** all arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently.
  - Mode 0: `address`+1.
  - Mode 1: `address`+`stride`. A `stride` of 0 gives a constant address.
  - Mode 2: `base`+`off`, where `off` counts 0 … `loop_len`−1 and then returns to 0.
  - Mode 3: Fibonacci LFSR with next = {a[9:0], a[10]^a[8]}, polynomial x^11+x^9+1. A seed of 0 is replaced by 1.
- **`last`:** equals (`issued_count` == `NUM_ADDR`−1) while `addr_valid`=1.
- **Entering DONE:** the final transfer deasserts `addr_valid` and `last` and asserts `done`. `issued_count` holds at `NUM_ADDR`.
- **New run:** `start` in DONE clears `issued_count` and `done`.
- **Reset values** (asynchronous, effective immediately, including mid-run):
  - State is IDLE.
  - `addr_valid`, `last`, `busy` and `done` are 0.
  - `address` is 0 and `issued_count` is 0.
  - After reset, no transfer occurs until a new `start`.

## Timing
- **Start latency:** `start` is sampled at edge N. At edge N+1 the block is in RUN with `addr_valid`=1, `address` = first address and `busy`=1.
- **Throughput:** one address per cycle while `addr_ready` is held at 1. There are no bubbles between transfers.
- **Backpressure:** while `addr_valid`=1 and `addr_ready`=0, `address`, `last` and `addr_valid` hold stable.
- **Ready independence:** `addr_valid` never depends combinationally on `addr_ready`.
- **Run length:** with `addr_ready` held at 1, a run takes exactly `NUM_ADDR` cycles from the first `addr_valid` to `done`=1.
- **Start in DONE:** `done` falls on the same edge that `addr_valid` rises.

## Test plan
- **Sequential with wrap:** `NUM_ADDR`=4, mode 0, `base`=0x7FE, `addr_ready`=1 → addresses 0x7FE, 0x7FF, 0x000, 0x001 on consecutive cycles. `last` is high only on 0x001. `done`=1 on the next cycle with `issued_count`=4.
- **Strided and loop:**
  - Mode 1, `base`=0x005, `stride`=3 → 0x005, 0x008, 0x00B, 0x00E.
  - Mode 2, `base`=0x100, `loop_len`=3 → 0x100, 0x101, 0x102, 0x100, 0x101.
  - Mode 2 with `loop_len`=0 → constant 0x100.
- **Random:**
  - Mode 3, seed 0x001 → 0x001, 0x002, 0x004, 0x008, 0x010, 0x020, 0x040, 0x080, 0x100, 0x201.
  - Seed 0 → first address 0x001.
  - Over 2047 transfers no value repeats and 0x000 never appears.
- **Backpressure:** mode 0, `base`=0x010. Drop `addr_ready` for 3 cycles after the first transfer → 0x011 is held stable with `addr_valid`=1 and `issued_count` frozen at 1. The stream resumes at 0x011, 0x012 with no skipped or duplicated addresses.
- **Start handling:**
  - `start` pulsed mid-run → ignored, and the count still ends at `NUM_ADDR`.
  - `mode`/`base` changed mid-run → no effect.
  - `start` in DONE → `issued_count` returns to 0 and a new run begins.
- **Reset mid-run:** assert `rst_n`=0 asynchronously, between edges, after 5 transfers → all outputs go to their reset values immediately. After release, the block stays in IDLE until `start`.
